counter_up_timer: RTL and testbench

//  Up-counting timer: counts 0..limit on qualified ticks (en), then either wraps (continuous) or stops (one-shot).

---
 rtl/counter_up_timer.sv | 168 ++++++++++++++++
 tb/tb_counter_up_timer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/counter_up_timer.sv
// -----------------------------------------------------------------------------
// counter_up_timer
//   Up-counting timer for the lab-2 datapath. Counts 0..limit on qualified
//   ticks (i_en) while running, then either wraps to 0 with a one-cycle carry
//   pulse (continuous mode) or parks at the limit and reports done (one-shot).
//   The carry output cascades instances (seconds -> minutes).
//
// Optional feature macro: COUNTER_UP_BCD_EN
//   When defined, adds o_bcd_tens / o_bcd_ones, the decimal digits of the
//   count (4'hF/4'hF when the count exceeds 99), aligned with o_result.
//
// Ports
//   clk         in   1      clock, all logic on posedge
//   reset       in   1      synchronous, active-high
//   i_start     in   1      clear count, latch limit/mode, enter RUN
//   i_stop      in   1      leave RUN, hold count
//   i_en        in   1      count tick qualifier (RUN only)
//   i_mode_wrap in   1      1 = continuous wrap, 0 = one-shot (sampled at start)
//   i_limit     in   WIDTH  terminal count, 0 selects DEFAULT_LIMIT
//   i_load      in   1      overwrite count with min(i_load_val, limit)
//   i_load_val  in   WIDTH  value for load
//   o_result    out  WIDTH  current count
//   o_carry     out  1      one-cycle pulse on wrap
//   o_done      out  1      one-shot reached its limit
//   o_busy      out  1      timer running
// -----------------------------------------------------------------------------
module counter_up_timer #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned DEFAULT_LIMIT = 59
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_en,
  input  logic             i_mode_wrap,
  input  logic [WIDTH-1:0] i_limit,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
`ifdef COUNTER_UP_BCD_EN
  output logic [3:0]       o_bcd_tens,
  output logic [3:0]       o_bcd_ones,
`endif
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_done,
  output logic             o_busy
);

  localparam logic [WIDTH-1:0] LP_DEFAULT_LIMIT = WIDTH'(DEFAULT_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_limit_q;
  logic [WIDTH-1:0] w_limit_nxt;
  logic             r_wrap_q;
  logic             w_wrap_nxt;
  logic [WIDTH-1:0] w_result_nxt;
  logic             w_carry_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;

`ifdef COUNTER_UP_BCD_EN
  // Packs {tens, ones} of a count; anything above 99 is flagged as F/F.
  function automatic logic [7:0] bcd_digits(input logic [WIDTH-1:0] v);
    if (32'(v) > 32'd99) begin
      return 8'hFF;
    end else begin
      return {4'(32'(v) / 32'd10), 4'(32'(v) % 32'd10)};
    end
  endfunction
`endif

  // Next-state, next-count and status decode with start > stop > load > count.
  always_comb begin
    w_state_nxt  = r_state;
    w_limit_nxt  = r_limit_q;
    w_wrap_nxt   = r_wrap_q;
    w_result_nxt = o_result;
    w_carry_nxt  = 1'b0;

    if (i_start) begin
      w_result_nxt = {WIDTH{1'b0}};
      w_limit_nxt  = (i_limit == {WIDTH{1'b0}}) ? LP_DEFAULT_LIMIT : i_limit;
      w_wrap_nxt   = i_mode_wrap;
      w_state_nxt  = ST_RUN;
    end else if (i_stop && (r_state == ST_RUN)) begin
      w_state_nxt = ST_IDLE;
    end else if (i_load) begin
      // Clamp so the count can never sit above the active limit.
      w_result_nxt = (i_load_val > r_limit_q) ? r_limit_q : i_load_val;
    end else if ((r_state == ST_RUN) && i_en) begin
      if (o_result < r_limit_q) begin
        w_result_nxt = o_result + {{(WIDTH-1){1'b0}}, 1'b1};
      end else if (r_wrap_q) begin
        w_result_nxt = {WIDTH{1'b0}};
        w_carry_nxt  = 1'b1;
      end else begin
        w_result_nxt = r_limit_q;
        w_state_nxt  = ST_DONE;
      end
    end else begin
      w_result_nxt = o_result;
    end

    case (w_state_nxt)
      ST_RUN: begin
        w_busy_nxt = 1'b1;
        w_done_nxt = 1'b0;
      end
      ST_DONE: begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b1;
      end
      default: begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
      end
    endcase
  end

  // State register; reset drops straight to IDLE and squashes any carry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_result  <= {WIDTH{1'b0}};
      o_carry   <= 1'b0;
      o_done    <= 1'b0;
      o_busy    <= 1'b0;
      r_limit_q <= LP_DEFAULT_LIMIT;
      r_wrap_q  <= 1'b1;
    end else begin
      o_result  <= w_result_nxt;
      o_carry   <= w_carry_nxt;
      o_done    <= w_done_nxt;
      o_busy    <= w_busy_nxt;
      r_limit_q <= w_limit_nxt;
      r_wrap_q  <= w_wrap_nxt;
    end
  end

`ifdef COUNTER_UP_BCD_EN
  // Digits are taken from the next count so they never lag o_result.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_bcd_tens <= 4'd0;
      o_bcd_ones <= 4'd0;
    end else begin
      {o_bcd_tens, o_bcd_ones} <= bcd_digits(w_result_nxt);
    end
  end
`endif

endmodule

// File: tb/tb_counter_up_timer.sv
module tb_counter_up_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_start;
  logic       i_stop;
  logic       i_en;
  logic       i_mode_wrap;
  logic [7:0] i_limit;
  logic       i_load;
  logic [7:0] i_load_val;
  logic [7:0] o_result;
  logic       o_carry;
  logic       o_done;
  logic       o_busy;
`ifdef COUNTER_UP_BCD_EN
  logic [3:0] o_bcd_tens;
  logic [3:0] o_bcd_ones;
`endif

  int tests = 0;
  int fails = 0;

  counter_up_timer #(.WIDTH(8), .DEFAULT_LIMIT(59)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_start     (i_start),
    .i_stop      (i_stop),
    .i_en        (i_en),
    .i_mode_wrap (i_mode_wrap),
    .i_limit     (i_limit),
    .i_load      (i_load),
    .i_load_val  (i_load_val),
`ifdef COUNTER_UP_BCD_EN
    .o_bcd_tens  (o_bcd_tens),
    .o_bcd_ones  (o_bcd_ones),
`endif
    .o_result    (o_result),
    .o_carry     (o_carry),
    .o_done      (o_done),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag, input logic [7:0] res,
                            input logic cy, input logic dn, input logic bz);
    chk({tag, ".result"}, 32'(o_result), 32'(res));
    chk({tag, ".carry"},  32'(o_carry),  32'(cy));
    chk({tag, ".done"},   32'(o_done),   32'(dn));
    chk({tag, ".busy"},   32'(o_busy),   32'(bz));
  endtask

  initial begin
    logic [7:0] exp1 [7];
    exp1 = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd1};

    reset = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_en = 1'b0; i_mode_wrap = 1'b0;
    i_limit = 8'd0; i_load = 1'b0; i_load_val = 8'd0;
    tick(); tick();
    reset = 1'b0;
    chk_status("reset", 8'd0, 1'b0, 1'b0, 1'b0);

    // Load while idle clamps against the default limit of 59.
    i_load = 1'b1; i_load_val = 8'd200; tick(); i_load = 1'b0;
    chk_status("idle_load_clamp", 8'd59, 1'b0, 1'b0, 1'b0);
    // en is ignored outside RUN.
    i_en = 1'b1; tick(); tick(); i_en = 1'b0;
    chk("idle_en_ignored", 32'(o_result), 32'd59);

    // 1: continuous wrap at limit 5.
    i_start = 1'b1; i_limit = 8'd5; i_mode_wrap = 1'b1; tick(); i_start = 1'b0;
    chk_status("t1_start", 8'd0, 1'b0, 1'b0, 1'b1);
    i_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk_status($sformatf("t1_cnt%0d", i), exp1[i], (i == 5), 1'b0, 1'b1);
    end
    i_en = 1'b0;

    // 2: one-shot at limit 3.
    i_start = 1'b1; i_limit = 8'd3; i_mode_wrap = 1'b0; tick(); i_start = 1'b0;
    i_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_status($sformatf("t2_cnt%0d", i), (i < 3) ? 8'(i + 1) : 8'd3,
                 1'b0, (i >= 3), (i < 3));
    end
    i_en = 1'b0;

    // 3: stop holds the count and ignores en.
    i_start = 1'b1; i_limit = 8'd9; i_mode_wrap = 1'b1; tick(); i_start = 1'b0;
    i_en = 1'b1; tick(); tick(); tick(); tick(); i_en = 1'b0;
    chk("t3_at4", 32'(o_result), 32'd4);
    i_stop = 1'b1; tick(); i_stop = 1'b0;
    chk_status("t3_stop", 8'd4, 1'b0, 1'b0, 1'b0);
    i_en = 1'b1; tick(); tick(); tick(); i_en = 1'b0;
    chk_status("t3_stop_en", 8'd4, 1'b0, 1'b0, 1'b0);
    i_start = 1'b1; tick(); i_start = 1'b0;
    chk_status("t3_restart", 8'd0, 1'b0, 1'b0, 1'b1);

    // 4: load clamps to limit 9, next tick wraps with carry.
    i_load = 1'b1; i_load_val = 8'd20; tick(); i_load = 1'b0;
    chk_status("t4_load", 8'd9, 1'b0, 1'b0, 1'b1);
    i_en = 1'b1; tick(); i_en = 1'b0;
    chk_status("t4_wrap", 8'd0, 1'b1, 1'b0, 1'b1);
    tick();
    chk_status("t4_carry_gone", 8'd0, 1'b0, 1'b0, 1'b1);
    i_en = 1'b1; tick(); tick();
    chk("t4_at2", 32'(o_result), 32'd2);
    i_start = 1'b1; i_load = 1'b1; i_load_val = 8'd5; tick();
    i_start = 1'b0; i_load = 1'b0; i_en = 1'b0;
    chk_status("t4_start_wins", 8'd0, 1'b0, 1'b0, 1'b1);

    // 5: limit 0 selects default 59.
    i_start = 1'b1; i_limit = 8'd0; i_mode_wrap = 1'b1; tick(); i_start = 1'b0;
    i_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      chk($sformatf("t5_cnt%0d", i), 32'(o_result), (i < 59) ? 32'(i + 1) : 32'd0);
      chk($sformatf("t5_cy%0d", i), 32'(o_carry), (i == 59) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 30; i++) tick();
    chk("t5_at30", 32'(o_result), 32'd30);
    reset = 1'b1; tick(); reset = 1'b0; i_en = 1'b0;
    chk_status("t5_reset30", 8'd0, 1'b0, 1'b0, 1'b0);
    // Reset on the edge that would wrap squashes the carry.
    i_start = 1'b1; i_limit = 8'd0; tick(); i_start = 1'b0;
    i_load = 1'b1; i_load_val = 8'd59; tick(); i_load = 1'b0;
    chk("t5_at59", 32'(o_result), 32'd59);
    i_en = 1'b1; reset = 1'b1; tick(); reset = 1'b0; i_en = 1'b0;
    chk_status("t5_reset_wrap", 8'd0, 1'b0, 1'b0, 1'b0);

    // Full-range limit wraps at all-ones.
    i_start = 1'b1; i_limit = 8'd255; i_mode_wrap = 1'b1; tick(); i_start = 1'b0;
    i_load = 1'b1; i_load_val = 8'd254; tick(); i_load = 1'b0;
    i_en = 1'b1; tick();
    chk_status("max_at255", 8'd255, 1'b0, 1'b0, 1'b1);
    tick(); i_en = 1'b0;
    chk_status("max_wrap", 8'd0, 1'b1, 1'b0, 1'b1);

`ifdef COUNTER_UP_BCD_EN
    // 6: decimal digits.
    i_start = 1'b1; i_limit = 8'd120; tick(); i_start = 1'b0;
    i_load = 1'b1; i_load_val = 8'd47; tick();
    chk("bcd47_t", 32'(o_bcd_tens), 32'd4); chk("bcd47_o", 32'(o_bcd_ones), 32'd7);
    i_load_val = 8'd99; tick();
    chk("bcd99_t", 32'(o_bcd_tens), 32'd9); chk("bcd99_o", 32'(o_bcd_ones), 32'd9);
    i_load_val = 8'd100; tick(); i_load = 1'b0;
    chk("bcd100_t", 32'(o_bcd_tens), 32'd15); chk("bcd100_o", 32'(o_bcd_ones), 32'd15);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("bcdrst_t", 32'(o_bcd_tens), 32'd0); chk("bcdrst_o", 32'(o_bcd_ones), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
